// File: rtl/tree_grng_pkg.sv
// Shared definitions for the streaming tree Gaussian RNG.
// Holds the Galois LFSR tap table (indexed by width), the per-lane seed salts,
// the walk FSM state enum and the default Gaussian threshold set
// (BITNUMS=8, THR_W=12), which benches and firmware write into the table.
package tree_grng_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        WALK     = 2'd1,
        STALL    = 2'd2
    } grngState_e;

    localparam int unsigned SALT_N     = 8;
    localparam int unsigned SALT_IDX_W = 3;

    // Lane 0 is unsalted so seed=0 exercises the zero-seed guard directly.
    localparam logic [31:0] LANE_SALT [SALT_N] = '{
        32'h0000_0000, 32'h5A3C_96E1, 32'hC3A5_1F7B, 32'h2B7E_1516,
        32'h9E37_79B9, 32'h6A09_E667, 32'hBB67_AE85, 32'h3C6E_F372
    };

    // Salt for any lane index; lanes past the table get a golden-ratio offset.
    function automatic logic [31:0] laneSalt(input int unsigned lane);
        return LANE_SALT[SALT_IDX_W'(lane % SALT_N)] ^ (32'(lane / SALT_N) * 32'h9E37_79B9);
    endfunction

    // Right-shift Galois toggle masks of maximal-length polynomials.
    function automatic logic [31:0] lfsrPoly(input int unsigned width);
        case (width)
            8:       lfsrPoly = 32'h0000_00B8;
            9:       lfsrPoly = 32'h0000_0110;
            10:      lfsrPoly = 32'h0000_0240;
            11:      lfsrPoly = 32'h0000_0500;
            12:      lfsrPoly = 32'h0000_0829;
            13:      lfsrPoly = 32'h0000_100D;
            14:      lfsrPoly = 32'h0000_2015;
            15:      lfsrPoly = 32'h0000_6000;
            16:      lfsrPoly = 32'h0000_D008;
            17:      lfsrPoly = 32'h0001_2000;
            18:      lfsrPoly = 32'h0002_0400;
            19:      lfsrPoly = 32'h0004_0023;
            20:      lfsrPoly = 32'h0009_0000;
            21:      lfsrPoly = 32'h0014_0000;
            22:      lfsrPoly = 32'h0030_0000;
            23:      lfsrPoly = 32'h0042_0000;
            24:      lfsrPoly = 32'h00E1_0000;
            25:      lfsrPoly = 32'h0120_0000;
            26:      lfsrPoly = 32'h0200_0023;
            27:      lfsrPoly = 32'h0400_0013;
            28:      lfsrPoly = 32'h0900_0000;
            29:      lfsrPoly = 32'h1400_0000;
            30:      lfsrPoly = 32'h2000_0029;
            31:      lfsrPoly = 32'h4800_0000;
            default: lfsrPoly = 32'h8020_0003;
        endcase
    endfunction

    localparam int GAUSS_BITS  = 8;
    localparam int GAUSS_THR_W = 12;
    localparam int GAUSS_M     = 85;

    // Target leaf weight: ways three values in 0..GAUSS_M sum to code
    // (Irwin-Hall shape, symmetric about 127.5).
    function automatic longint gaussWeight(input int code);
        longint acc;
        longint t;
        longint coef;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            coef = (j == 0) ? 1 : (j == 1) ? -3 : (j == 2) ? 3 : -1;
            t    = longint'(code) - longint'(j) * longint'(GAUSS_M + 1) + 2;
            if (t >= 2) acc = acc + coef * ((t * (t - 1)) / 2);
        end
        return acc;
    endfunction

    // Threshold of a heap node = P(right subtree | node) scaled to THR_W bits.
    function automatic logic [GAUSS_THR_W-1:0] gaussThr(input int unsigned node);
        int     depth;
        int     span;
        int     lo;
        longint wAll;
        longint wHi;
        longint q;
        depth = 0;
        for (int b = 1; b < GAUSS_BITS; b++) begin
            if (node >= (32'd1 << b)) depth = b;
        end
        span = 1 << (GAUSS_BITS - depth);
        lo   = (int'(node) - (1 << depth)) * span;
        wAll = 0;
        wHi  = 0;
        for (int c = 0; c < span; c++) begin
            wAll = wAll + gaussWeight(lo + c);
            if (c >= span / 2) wHi = wHi + gaussWeight(lo + c);
        end
        if (wAll == 0) return GAUSS_THR_W'(2048);
        q = (wHi * 4096 + wAll / 2) / wAll;
        if (q > 4095) q = 4095;
        return GAUSS_THR_W'(q);
    endfunction

endpackage

// File: rtl/tree_grng_stream_if.sv
// Command/stream bundle of tree_grng_stream.
//   master (producer of commands, consumer of samples):
//     LD_seed, seed, thr_we, thr_addr, thr_data, out_ready -> ; <- out_valid, result
//   slave (the generator): the mirror image.
interface tree_grng_stream_if #(
    parameter int unsigned BITNUMS = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned LFSR_W  = 16,
    parameter int unsigned THR_W   = 12
) ();
    logic                     LD_seed;
    logic [LFSR_W-1:0]        seed;
    logic                     thr_we;
    logic [BITNUMS-1:0]       thr_addr;
    logic [THR_W-1:0]         thr_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NCH*BITNUMS-1:0]   result;

    modport master (
        output LD_seed, seed, thr_we, thr_addr, thr_data, out_ready,
        input  out_valid, result
    );

    modport slave (
        input  LD_seed, seed, thr_we, thr_addr, thr_data, out_ready,
        output out_valid, result
    );
endinterface

// File: rtl/grng_lfsr_lane.sv
// One lane's right-shift Galois LFSR with load, step and zero-seed guard.
// Ports: clk, rst (sync, active-high), load, step, seedVal (LFSR_W),
//        sampleVal (THR_W) = top THR_W bits of the current state.
module grng_lfsr_lane
    import tree_grng_pkg::*;
#(
    parameter int unsigned LFSR_W = 16,
    parameter int unsigned THR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seedVal,
    output logic [THR_W-1:0]  sampleVal
);
    localparam logic [LFSR_W-1:0] POLY = LFSR_W'(lfsrPoly(LFSR_W));

    logic [LFSR_W-1:0] lfsrQ;

    // A zero seed would lock the register, so it is replaced by 1.
    always_ff @(posedge clk) begin
        if (rst)       lfsrQ <= '0;
        else if (load) lfsrQ <= (seedVal == '0) ? LFSR_W'(1) : seedVal;
        else if (step) lfsrQ <= (lfsrQ >> 1) ^ (lfsrQ[0] ? POLY : '0);
    end

    assign sampleVal = lfsrQ[LFSR_W-1 -: THR_W];
endmodule

// File: rtl/tree_grng_stream.sv
// Streaming tree Gaussian RNG: NCH lanes each walk a BITNUMS-level heap of
// runtime-writable thresholds, one level per clock, and present the NCH codes
// together on a valid/ready stream.
// Ports: clk, rst (sync, active-high), bus (tree_grng_stream_if.slave):
//   LD_seed/seed restart all lanes; thr_we/thr_addr/thr_data write a node;
//   out_valid/out_ready/result carry lane i in result[i*BITNUMS +: BITNUMS].
// Option: TREE_GRNG_TWOS_EN inverts each lane MSB so codes are two's complement.
module tree_grng_stream
    import tree_grng_pkg::*;
#(
    parameter int unsigned BITNUMS = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned LFSR_W  = 16,
    parameter int unsigned THR_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    tree_grng_stream_if.slave   bus
);
    localparam int unsigned        NODES    = 1 << BITNUMS;
    localparam int unsigned        LVL_W    = $clog2(BITNUMS);
    localparam logic [LVL_W-1:0]   LAST_LVL = LVL_W'(BITNUMS - 1);
    localparam logic [THR_W-1:0]   THR_RST  = THR_W'(1 << (THR_W - 1));
`ifdef TREE_GRNG_TWOS_EN
    localparam logic [BITNUMS-1:0] MSB_FLIP = BITNUMS'(1 << (BITNUMS - 1));
`else
    localparam logic [BITNUMS-1:0] MSB_FLIP = '0;
`endif

    grngState_e               state;
    grngState_e               stateNext;
    logic [THR_W-1:0]         thrTab [1:NODES-1];
    logic [LVL_W-1:0]         level;
    logic [BITNUMS-1:0]       node [NCH];
    logic [THR_W-1:0]         sample [NCH];
    logic [NCH-1:0]           bitC;
    logic [NCH*BITNUMS-1:0]   codeC;
    logic [NCH*BITNUMS-1:0]   resultQ;
    logic                     outValid;
    logic                     atLast;
    logic                     stepLanes;
    logic                     loadResult;

    for (genvar i = 0; i < NCH; i++) begin : gLane
        grng_lfsr_lane #(.LFSR_W(LFSR_W), .THR_W(THR_W)) uLane (
            .clk       (clk),
            .rst       (rst),
            .load      (bus.LD_seed),
            .step      (stepLanes),
            .seedVal   (bus.seed ^ LFSR_W'(laneSalt(i))),
            .sampleVal (sample[i])
        );
    end

    assign atLast = (level == LAST_LVL);

    // Branch decision per lane and the code it would complete at the last level.
    always_comb begin
        bitC  = '0;
        codeC = '0;
        for (int i = 0; i < NCH; i++) begin
            bitC[i] = (sample[i] < thrTab[node[i]]);
            codeC[i*BITNUMS +: BITNUMS] = {node[i][BITNUMS-2:0], bitC[i]} ^ MSB_FLIP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= UNSEEDED;
        else     state <= stateNext;
    end

    // Walk control; a stalled last level completes as soon as the output frees.
    always_comb begin
        stateNext  = state;
        stepLanes  = 1'b0;
        loadResult = 1'b0;
        if (bus.LD_seed) begin
            stateNext = WALK;
        end else begin
            case (state)
                UNSEEDED: stateNext = UNSEEDED;
                WALK, STALL: begin
                    if (!atLast) begin
                        stepLanes = 1'b1;
                    end else if (!outValid || bus.out_ready) begin
                        stepLanes  = 1'b1;
                        loadResult = 1'b1;
                        stateNext  = WALK;
                    end else begin
                        stateNext = STALL;
                    end
                end
                default: stateNext = UNSEEDED;
            endcase
        end
    end

    // Threshold table; node 0 does not exist.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 1; n < NODES; n++) thrTab[n] <= THR_RST;
        end else if (bus.thr_we && (bus.thr_addr != '0)) begin
            thrTab[bus.thr_addr] <= bus.thr_data;
        end
    end

    // Level counter and per-lane heap position.
    always_ff @(posedge clk) begin
        if (rst || bus.LD_seed) begin
            level <= '0;
            for (int i = 0; i < NCH; i++) node[i] <= BITNUMS'(1);
        end else if (stepLanes) begin
            level <= loadResult ? '0 : level + LVL_W'(1);
            for (int i = 0; i < NCH; i++)
                node[i] <= loadResult ? BITNUMS'(1) : {node[i][BITNUMS-2:0], bitC[i]};
        end
    end

    // Output register; a seed load drops any pending sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid <= 1'b0;
            resultQ  <= '0;
        end else if (bus.LD_seed) begin
            outValid <= 1'b0;
        end else if (loadResult) begin
            outValid <= 1'b1;
            resultQ  <= codeC;
        end else if (bus.out_ready) begin
            outValid <= 1'b0;
        end
    end

    assign bus.out_valid = outValid;
    assign bus.result    = resultQ;
endmodule
